wb_lsu_master: RTL and testbench

//  Wishbone pipelined-mode bus initiator between the core load/store unit and the

---
 rtl/wb_lsu_master.sv | 175 +++++++++++++++++
 tb/tb_wb_lsu_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_lsu_master.sv
// rtl/wb_lsu_master.sv - Wishbone pipelined-mode initiator for the core load/store unit
// One request in flight: IDLE -> REQ -> WAIT -> RESP, with lane steering, extension and timeout.
module wb_lsu_master #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [XLEN-3:0]   adr_o,
  output logic [XLEN/8-1:0] sel_o,
  output logic [XLEN-1:0]   dat_o,
  input  logic [XLEN-1:0]   dat_i,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic              stall_i
);

  localparam int SW = XLEN / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic          unsigned_q;

  logic            misaligned;
  logic [SW-1:0]   sel_next;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] rdata_ext;
  logic            done;
  logic            done_err;

  assign req_ready_o = (state == S_IDLE);

  always_comb begin
    misaligned = (req_size_i == 2'd3) ||
                 (req_size_i == 2'd1 && req_addr_i[0]) ||
                 (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00);
    case (req_size_i)
      2'd0: begin
        sel_next  = SW'(1) << req_addr_i[1:0];
        wdata_rep = {SW{req_wdata_i[7:0]}};
      end
      2'd1: begin
        sel_next  = SW'(4'b0011) << req_addr_i[1:0];
        wdata_rep = {(XLEN/16){req_wdata_i[15:0]}};
      end
      default: begin
        sel_next  = SW'(4'b1111);
        wdata_rep = req_wdata_i;
      end
    endcase
  end

  // Lane-align the returned word using the offset and size latched at accept time.
  always_comb begin
    rshift = dat_i >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    rdata_ext = {{(XLEN-8){~unsigned_q & rshift[7]}}, rshift[7:0]};
      2'd1:    rdata_ext = {{(XLEN-16){~unsigned_q & rshift[15]}}, rshift[15:0]};
      default: rdata_ext = rshift;
    endcase
  end

  // A strobe still stalled cannot complete, so ack/err only count in REQ once stall_i is low.
  always_comb begin
    done     = 1'b0;
    done_err = 1'b0;
    case (state)
      S_REQ: begin
        if (!stall_i && (ack_i || err_i)) begin
          done     = 1'b1;
          done_err = err_i;
        end else if (timer == TLAST) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      S_WAIT: begin
        if (ack_i || err_i) begin
          done     = 1'b1;
          done_err = err_i;
        end else if (timer == TLAST) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      timer       <= '0;
      size_q      <= 2'd0;
      lane_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      sel_o       <= '0;
      dat_o       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            timer      <= '0;
            size_q     <= req_size_i;
            lane_q     <= req_addr_i[1:0];
            unsigned_q <= req_unsigned_i;
            if (misaligned) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              state <= S_REQ;
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              we_o  <= req_we_i;
              adr_o <= req_addr_i[XLEN-1:2];
              sel_o <= sel_next;
              dat_o <= wdata_rep;
            end
          end
        end
        S_REQ, S_WAIT: begin
          timer <= timer + TW'(1);
          if (done) begin
            state       <= S_RESP;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= done_err;
            rsp_rdata_o <= (done_err || we_o) ? '0 : rdata_ext;
          end else if (state == S_REQ && !stall_i) begin
            state <= S_WAIT;
            stb_o <= 1'b0;
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb/tb_wb_lsu_master.sv - directed table, reset/idle sequences and random traffic for wb_lsu_master
// A scripted slave drives stall/ack/err by cycle number relative to the accept edge.
module tb_wb_lsu_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cyc_o, stb_o, we_o;
  logic [29:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o, dat_i;
  logic        ack_i, err_i, stall_i;

  always #5 clk = ~clk;

  wb_lsu_master #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    int          ack_lat;   // cycles from strobe taken to termination, -1 = never
    int          term;      // 0 ack, 1 err, 2 both
    logic        exp_bus;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int stall, input int ack_lat,
                              input int term, input logic bus, input logic [3:0] esel,
                              input logic [31:0] edat, input logic eerr,
                              input logic [31:0] erd, input int elat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.stall = stall; v.ack_lat = ack_lat; v.term = term;
    v.exp_bus = bus; v.exp_sel = esel; v.exp_dat = edat; v.exp_err = eerr;
    v.exp_rdata = erd; v.exp_lat = elat;
    return v;
  endfunction

  // Reference: byte-lane view of the transfer plus cycle arithmetic on the slave schedule.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int nb, off, s, a;
    logic sgn;
    r = v;
    off = int'(v.addr[1:0]);
    r.exp_sel = '0; r.exp_dat = '0; r.exp_rdata = '0; r.exp_err = 1'b0;
    nb = (v.size == 2'd3) ? 0 : (1 << v.size);
    r.exp_bus = (nb != 0) && ((off % nb) == 0);
    if (!r.exp_bus) begin
      r.exp_err = 1'b1;
      r.exp_lat = 1;
      return r;
    end
    for (int i = 0; i < 4; i++) begin
      r.exp_sel[i]       = (i >= off) && (i < off + nb);
      r.exp_dat[8*i +: 8] = v.wdata[8*(i % nb) +: 8];
    end
    s = v.stall + 1;
    a = s + v.ack_lat;
    if (v.ack_lat < 0 || a > TO) begin
      r.exp_err = 1'b1;
      r.exp_lat = TO + 1;
    end else begin
      r.exp_lat = a + 1;
      r.exp_err = (v.term != 0);
      if (!r.exp_err && !v.we) begin
        sgn = !v.uns && v.rdata[8*(off+nb)-1];
        for (int i = 0; i < 4; i++)
          r.exp_rdata[8*i +: 8] = (i < nb) ? v.rdata[8*(off+i) +: 8] : {8{sgn}};
      end
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int stb_cnt = 0, cyc_cnt = 0, rsp_cnt = 0, first = -1, a, exp_stb;
    logic seen = 1'b0, unstable = 1'b0, err_at = 1'b0, cyc_at = 1'b1, ready_after = 1'b0;
    logic [29:0] adr0 = '0;
    logic [3:0]  sel0 = '0;
    logic        we0 = 1'b0;
    logic [31:0] dat0 = '0, rd_at = '0;
    a = v.stall + 1 + v.ack_lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    stall_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      req_size = 2'($urandom_range(0, 3));
      if (cyc_o) cyc_cnt++;
      if (stb_o) begin
        if (!seen) begin
          seen = 1'b1; adr0 = adr_o; sel0 = sel_o; we0 = we_o; dat0 = dat_o;
        end else if (adr_o !== adr0 || sel_o !== sel0 || we_o !== we0 || dat_o !== dat0) begin
          unstable = 1'b1;
        end
        stb_cnt++;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (first < 0) begin
          first = k; err_at = rsp_err; rd_at = rsp_rdata; cyc_at = cyc_o;
        end
      end
      if (first >= 0 && k == first + 1) begin
        ready_after = req_ready;
        break;
      end
      stall_i = (k <= v.stall);
      if (v.ack_lat >= 0 && k == a) begin
        ack_i = (v.term != 1); err_i = (v.term != 0); dat_i = v.rdata;
      end else begin
        ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
      end
    end
    stall_i = 1'b0; ack_i = 1'b0; err_i = 1'b0;
    check({tag, "_lat"}, 32'(first), 32'(v.exp_lat));
    check({tag, "_rsp_count"}, 32'(rsp_cnt), 32'd1);
    check({tag, "_err"}, 32'(err_at), 32'(v.exp_err));
    check({tag, "_rdata"}, rd_at, v.exp_rdata);
    check({tag, "_cyc_at_rsp"}, 32'(cyc_at), 32'd0);
    check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
    check({tag, "_cyc_cycles"}, 32'(cyc_cnt), v.exp_bus ? 32'(v.exp_lat - 1) : 32'd0);
    if (v.exp_bus) begin
      exp_stb = (v.stall + 1 < TO) ? v.stall + 1 : TO;
      check({tag, "_stb_cycles"}, 32'(stb_cnt), 32'(exp_stb));
      check({tag, "_adr"}, 32'(adr0), 32'(v.addr[31:2]));
      check({tag, "_sel"}, 32'(sel0), 32'(v.exp_sel));
      check({tag, "_we"}, 32'(we0), 32'(v.we));
      check({tag, "_stable"}, 32'(unstable), 32'd0);
      if (v.we) check({tag, "_dat"}, dat0, v.exp_dat);
    end
  endtask

  vec_t tbl[17];
  vec_t rv;
  logic bad;
  int   r;

  initial begin
    tbl[0]  = mk(1, 2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 1, 0, 1, 4'hF, 32'hDEADBEEF, 0, 0, 3);
    tbl[1]  = mk(0, 0, 1, 32'h103, 0, 32'h80AABBCC, 0, 1, 0, 1, 4'b1000, 0, 0, 32'h00000080, 3);
    tbl[2]  = mk(0, 0, 0, 32'h103, 0, 32'h80AABBCC, 0, 1, 0, 1, 4'b1000, 0, 0, 32'hFFFFFF80, 3);
    tbl[3]  = mk(1, 1, 0, 32'h102, 32'h1234, 0, 3, 1, 0, 1, 4'b1100, 32'h12341234, 0, 0, 6);
    tbl[4]  = mk(0, 2, 0, 32'h102, 0, 32'h11111111, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[5]  = mk(0, 2, 0, 32'h104, 0, 0, 0, -1, 0, 1, 4'hF, 0, 1, 0, 9);
    tbl[6]  = mk(0, 2, 0, 32'h108, 0, 32'h55555555, 0, 1, 2, 1, 4'hF, 0, 1, 0, 3);
    tbl[7]  = mk(0, 2, 1, 32'h200, 0, 32'h11223344, 0, 0, 0, 1, 4'hF, 0, 0, 32'h11223344, 2);
    tbl[8]  = mk(0, 1, 0, 32'h102, 0, 32'hBEEF0000, 0, 1, 0, 1, 4'b1100, 0, 0, 32'hFFFFBEEF, 3);
    tbl[9]  = mk(0, 1, 1, 32'h100, 0, 32'h1234ABCD, 0, 1, 0, 1, 4'b0011, 0, 0, 32'h0000ABCD, 3);
    tbl[10] = mk(0, 3, 0, 32'h0, 0, 32'h12345678, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[11] = mk(1, 1, 0, 32'h101, 32'hFFFF, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[12] = mk(0, 0, 0, 32'h101, 0, 32'h00007F00, 0, 1, 0, 1, 4'b0010, 0, 0, 32'h0000007F, 3);
    tbl[13] = mk(0, 2, 0, 32'h10, 0, 32'hCAFEF00D, 6, 1, 0, 1, 4'hF, 0, 0, 32'hCAFEF00D, 9);
    tbl[14] = mk(0, 2, 0, 32'h14, 0, 32'hCAFEF00D, 7, 1, 0, 1, 4'hF, 0, 1, 0, 9);
    tbl[15] = mk(1, 0, 0, 32'h21, 32'hA5, 0, 0, 2, 1, 1, 4'b0010, 32'hA5A5A5A5, 1, 0, 4);
    tbl[16] = mk(1, 0, 0, 32'h22, 32'h12345678, 0, 0, 1, 0, 1, 4'b0100, 32'h78787878, 0, 0, 3);

    rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0; stall_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {cyc_o, stb_o, we_o, rsp_valid, rsp_err, 27'd0},
          32'd0);
    check("reset_adr_sel", {adr_o[27:0], sel_o}, 32'd0);
    check("reset_dat_rdata", dat_o | rsp_rdata, 32'd0);
    check("reset_ready", 32'(req_ready), 32'd1);
    rst_ni = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("t%0d", i));

    // Terminations while no cycle is open must be ignored.
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid || cyc_o) bad = 1'b1;
      ack_i = (k < 3); err_i = (k < 3); dat_i = $urandom;
    end
    @(negedge clk);
    if (rsp_valid || cyc_o) bad = 1'b1;
    check("idle_term_ignored", 32'(bad), 32'd0);

    // Reset while waiting for an ack: cycle drops immediately and no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wait_cyc_before", 32'(cyc_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rst_wait_cyc_dropped", {30'd0, cyc_o, stb_o}, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) rst_ni = 1'b1;
      if (rsp_valid || cyc_o) bad = 1'b1;
    end
    check("rst_wait_no_rsp", 32'(bad), 32'd0);

    for (int i = 0; i < 60; i++) begin
      rv.we = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      rv.size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      rv.uns = 1'($urandom_range(0, 1));
      rv.addr = $urandom;
      if ($urandom_range(0, 2) != 0) rv.addr[1:0] = (rv.size == 2'd1) ? {rv.addr[1], 1'b0} :
                                                    (rv.size == 2'd2) ? 2'b00 : rv.addr[1:0];
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      r = $urandom_range(0, 9);
      rv.stall = (r < 5) ? 0 : (r < 8) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 9));
      rv.ack_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      rv.term = (r < 7) ? 0 : (r < 9) ? 1 : 2;
      rv = model(rv);
      run_vec(rv, $sformatf("r%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
